mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit for the 5-stage RV32I pipeline. It consumes the EX/MEM register outputs (address, store data, PC+4, destination register) and drives a single-outstanding req/ack data bus. It stalls the pipeline while an access is pending. It registers the MEM/WB outputs, including the aligned and extended load data, for the writeback mux.

## Interface
- Parameters: none (XLEN fixed at 32).
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage; never high together with MemReadM.
- RegWriteM  in  1  instruction writes rd.
- Funct3M  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  32  effective address, or ALU result for non-memory ops.
- BM  in  32  store data (rs2).
- Adder4M  in  32  PC+4.
- RDM  in  5  destination register.
- DReq  out  1  bus request.
- DWe  out  1  1 = write.
- DAddr  out  32  word address {ALUResultM[31:2],2'b00}.
- DBe  out  4  byte enables.
- DWData  out  32  lane-replicated store data.
- DAck  in  1  bus completion; read data valid in the same cycle.
- DRData  in  32  read word.
- StallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- ReadDataW, ALUResultW, Adder4W  out  32 each  MEM/WB data.
- RDW  out  5  MEM/WB rd.
- RegWriteW  out  1  MEM/WB write enable.
- MisalignW  out  1  misalignment flag; present only with LSU_MISALIGN_TRAP_EN.

## Operation
- FSM states IDLE and BUSY. Reset state is IDLE.
- Memory op = MemReadM | MemWriteM.
- IDLE, no memory op: no bus activity; StallM=0; MEM/WB captures the inputs at the next edge.
- IDLE, memory op: DReq=1 combinationally; DWe=MemWriteM.
  - DAck=1 in the same cycle: zero-wait access; StallM=0; MEM/WB captures at this edge; stay in IDLE.
  - DAck=0: StallM=1; go to BUSY.
- BUSY: DReq, DWe, DAddr, DBe and DWData are held from registered copies captured on entry, regardless of input changes. StallM = !DAck.
  - On DAck: capture into MEM/WB; go to IDLE.
- While stalled, MEM/WB receives a bubble: RegWriteW=0, data fields hold their previous values.
- Store lanes:
  - SB: DBe = 0001 << a[1:0]; DWData = {4{BM[7:0]}}.
  - SH: DBe = 0011 << {a[1],1'b0}; DWData = {2{BM[15:0]}}.
  - SW: DBe = 1111; DWData = BM.
- Load lanes:
  - Select byte a[1:0] or halfword a[1] of DRData.
  - Sign-extend for B/H, zero-extend for BU/HU; W passes through.
  - DBe reports the same mask as the store case.
- Without the macro, misaligned addresses are force-aligned: a[0] is ignored for H; a[1:0] are ignored for W.
- Reset mid-access: FSM returns to IDLE; DReq drops immediately; a late DAck in IDLE with no memory op is ignored.

## Timing
- Reset values: every registered output is 0, including ReadDataW, ALUResultW, Adder4W, RDW, RegWriteW and MisalignW. The FSM is in IDLE.
- Latency: MEM to W is 1 cycle at zero wait. With N wait cycles, StallM is high for N cycles and MEM/WB updates at the DAck edge.
- DReq is never asserted in consecutive accesses without an intervening DAck (single outstanding request).
- DAck is sampled only while DReq=1.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access (H with a[0]=1, W with a[1:0]≠0) is not issued: DReq=0, StallM=0.
  - Next edge: MisalignW=1 and RegWriteW=0.
  - MisalignW is 0 for every other instruction.
- Undefined: the MisalignW port and its logic are absent; force-alignment applies.

## Structure
- Shared package riscv_pkg holds:
  - Funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - LSU state encoding (LSU_IDLE, LSU_BUSY).
- One combinational sub-module, lsu_align, handles the byte-enable/store replication and load extract/extend datapath. The FSM and MEM/WB register stay in mem_stage_lsu.

## Test plan
- Non-memory op: ALUResultM=0x1234, RDM=5, RegWriteM=1. Next edge: ALUResultW=0x1234, RDW=5, RegWriteW=1; DReq stays 0.
- Zero-wait LB: a=0x103, DRData=0x80FF_FF00, DAck high with DReq. Response: DBe=1000; next edge ReadDataW=0xFFFF_FF80; StallM never asserted.
- SH with 3 wait cycles: a=0x202, BM=0xAAAA_BEEF. Response: DBe=1100, DWData=0xBEEF_BEEF, DWe=1; StallM high exactly 3 cycles; bus outputs stable throughout; RegWriteW=0 during the stall.
- LHU after 1 wait: a=0x300, DRData=0x1234_F00D. Response: ReadDataW=0x0000_F00D.
- Async reset asserted in BUSY: DReq, StallM and all W outputs go to 0 immediately. After release with no memory op, a stray DAck has no effect.
- LSU_MISALIGN_TRAP_EN, LW at a=0x402: DReq stays 0, StallM=0; next edge MisalignW=1, RegWriteW=0. Without the macro: DAddr=0x400, DBe=1111.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
// - Funct3 width/sign codes for loads and stores.
// - LSU FSM state encoding.
// - lsu_req_t: one MEM-stage memory request, as held while the bus is busy.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] bm;
    logic [31:0] add4;
    logic [4:0]  rd;
    logic        rw;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane datapath for the LSU.
// Ports:
//   funct3    in  3   access width/sign
//   a         in  2   low address bits
//   wdata_in  in  32  store data (rs2)
//   rdata_in  in  32  bus read word
//   be        out 4   byte enables (same mask for loads and stores)
//   wdata     out 32  lane-replicated store data
//   rdata_ext out 32  selected and extended load data
// Misaligned offsets are force-aligned here: a[0] is dropped for
// halfwords and both bits are dropped for words.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] sh;
  logic [15:0] hw;

  always_comb begin
    sh        = rdata_in >> {a, 3'b000};
    hw        = a[1] ? rdata_in[31:16] : rdata_in[15:0];
    be        = 4'b1111;
    wdata     = wdata_in;
    rdata_ext = rdata_in;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << a;
        wdata     = {4{wdata_in[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << {a[1], 1'b0};
        wdata     = {2{wdata_in[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{hw[15]}}, hw} : {16'h0, hw};
      end
      default: ; // word: full mask, data passes through
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the 5-stage RV32I pipeline: drives a single-outstanding
// req/ack data bus, stalls the pipeline while an access is pending and
// registers the MEM/WB outputs.
// Ports:
//   clk, rst (async, active low)
//   EX/MEM in : MemReadM, MemWriteM, RegWriteM, Funct3M, ALUResultM, BM, Adder4M, RDM
//   bus        : DReq, DWe, DAddr, DBe, DWData out; DAck, DRData in
//   StallM     : freezes PC, IF/ID, ID/EX, EX/MEM
//   MEM/WB out : ReadDataW, ALUResultW, Adder4W, RDW, RegWriteW
//   MisalignW  : only with LSU_MISALIGN_TRAP_EN defined; misaligned H/W
//                accesses are then suppressed and flagged instead of issued.
module mem_stage_lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        RegWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] BM,
  input  logic [31:0] Adder4M,
  input  logic [4:0]  RDM,
  output logic        DReq,
  output logic        DWe,
  output logic [31:0] DAddr,
  output logic [3:0]  DBe,
  output logic [31:0] DWData,
  input  logic        DAck,
  input  logic [31:0] DRData,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] Adder4W,
  output logic [4:0]  RDW,
  output logic        RegWriteW
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        MisalignW
`endif
);

  lsu_state_t state, nxt;
  lsu_req_t   live, held, cur;
  logic       memop, cur_ld, req, stall, cap, trap, save;
  logic [31:0] rdata_ext;

  assign memop = MemReadM | MemWriteM;
  assign live  = '{we: MemWriteM, f3: Funct3M, addr: ALUResultM, bm: BM,
                   add4: Adder4M, rd: RDM, rw: RegWriteM};
  // In BUSY the bus is driven from the copy taken on entry so that
  // upstream changes cannot disturb an in-flight access.
  assign cur    = (state == LSU_BUSY) ? held : live;
  assign cur_ld = (state == LSU_BUSY) ? !held.we : MemReadM;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  always_comb begin
    mis = 1'b0;
    case (live.f3)
      F3_H, F3_HU:  mis = live.addr[0];
      F3_B, F3_BU:  mis = 1'b0;
      default:      mis = |live.addr[1:0];
    endcase
  end
`else
  logic mis;
  assign mis = 1'b0;
`endif

  lsu_align u_align (
    .funct3    (cur.f3),
    .a         (cur.addr[1:0]),
    .wdata_in  (cur.bm),
    .rdata_in  (DRData),
    .be        (DBe),
    .wdata     (DWData),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    nxt   = state;
    req   = 1'b0;
    stall = 1'b0;
    cap   = 1'b0;
    trap  = 1'b0;
    save  = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (memop && mis) begin
          trap = 1'b1;
          cap  = 1'b1;
        end else if (memop) begin
          req = 1'b1;
          if (DAck) begin
            cap = 1'b1;
          end else begin
            stall = 1'b1;
            save  = 1'b1;
            nxt   = LSU_BUSY;
          end
        end else begin
          cap = 1'b1;
        end
      end
      LSU_BUSY: begin
        req = 1'b1;
        if (DAck) begin
          cap = 1'b1;
          nxt = LSU_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: nxt = LSU_IDLE;
    endcase
  end

  // Gate with reset so the request drops the moment reset asserts,
  // even though the EX/MEM inputs may still show a memory op.
  assign DReq   = rst & req;
  assign StallM = rst & stall;
  assign DWe    = DReq & cur.we;
  assign DAddr  = {cur.addr[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LSU_IDLE;
      held       <= '0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      Adder4W    <= '0;
      RDW        <= '0;
      RegWriteW  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (save) held <= live;
      if (cap) begin
        ALUResultW <= cur.addr;
        Adder4W    <= cur.add4;
        RDW        <= cur.rd;
        RegWriteW  <= cur.rw & !trap;
        if (cur_ld && !trap) ReadDataW <= rdata_ext;
      end else begin
        RegWriteW  <= 1'b0; // bubble while stalled; data fields hold
      end
`ifdef LSU_MISALIGN_TRAP_EN
      MisalignW <= trap;
`endif
    end
  end

endmodule
